// File: rtl/mmips_hilo_pkg.sv
// Shared encodings for the mMIPS HI/LO controller: op codes, ALU ctrl
// code borrowed for MULTU, FSM states and the latched divide sign info.
package mmips_hilo_pkg;

    localparam int          WIDTH_DEF    = 32;
    localparam logic [5:0]  MUL_CTRL_DEF = 6'h13;

    typedef logic [2:0] op_t;
    localparam op_t OP_NOP  = 3'd0;
    localparam op_t OP_MULTU = 3'd1;
    localparam op_t OP_DIVU = 3'd2;
    localparam op_t OP_DIV  = 3'd3;
    localparam op_t OP_MFHI = 3'd4;
    localparam op_t OP_MFLO = 3'd5;
    localparam op_t OP_MTHI = 3'd6;
    localparam op_t OP_MTLO = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_FIX  = 2'd3;

    // Captured at accept time so FIX knows how to finish the divide.
    typedef struct packed {
        logic q_neg;  // negate quotient (signed DIV, operand signs differ)
        logic r_neg;  // negate remainder (signed DIV, dividend negative)
        logic dz;     // divisor was zero
    } div_sgn_t;

    function automatic logic is_div_op(input op_t o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit
// per cycle. A start pulse loads the operands; WIDTH steps follow.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [WIDTH:0]   rem_sh, diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvsr};
    end

    // Load on start, then shift in one quotient bit per cycle until cnt hits 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvsr <= '0;
        end else if (start) begin
            cnt  <= CW'(WIDTH);
            rem  <= '0;
            quo  <= dividend;
            dvsr <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // done marks the cycle performing the final step; results are stable
    // in the following cycle.
    assign done      = (cnt == CW'(1));
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller for the mMIPS execute stage: owns HI/LO, sequences
// MULTU through the shared ALU and divides with div_core.
module hilo_ctrl
    import mmips_hilo_pkg::*;
#(
    parameter int         WIDTH    = WIDTH_DEF,
    parameter logic [5:0] MUL_CTRL = MUL_CTRL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       ex_ctrl,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    output logic [5:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [WIDTH-1:0] alu_r2,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             stall,
    output logic             div_by_zero
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] hi, lo, op_a, op_b;
    div_sgn_t         sgn;
    logic             accept, b_zero, div_start, div_done;
    logic [WIDTH-1:0] a_mag, b_mag, quo, rem, q_fix, r_fix;

    assign accept    = (state == ST_IDLE) && op_valid;
    assign b_zero    = (b == '0);
    assign div_start = accept && is_div_op(op) && !b_zero;
    assign a_mag     = ((op == OP_DIV) && a[WIDTH-1]) ? -a : a;
    assign b_mag     = ((op == OP_DIV) && b[WIDTH-1]) ? -b : b;
    assign q_fix     = sgn.q_neg ? -quo : quo;
    assign r_fix     = sgn.r_neg ? -rem : rem;

    div_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    // Next-state: MT*/MF* complete in IDLE; a zero divisor skips to FIX.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (op == OP_MULTU)      state_nxt = ST_MUL;
                else if (is_div_op(op)) state_nxt = b_zero ? ST_FIX : ST_DIV;
            end
            ST_MUL:  state_nxt = ST_IDLE;
            ST_DIV:  if (div_done) state_nxt = ST_FIX;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Latch operands and divide sign info on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
            sgn  <= '0;
        end else if (accept) begin
            op_a      <= a;
            op_b      <= b;
            sgn.q_neg <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn.r_neg <= (op == OP_DIV) && a[WIDTH-1];
            sgn.dz    <= is_div_op(op) && b_zero;
        end
    end

    // HI/LO writes: MT* at accept, MULTU at end of MUL, divides at end of FIX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && (op == OP_MTHI)) begin
            hi <= a;
        end else if (accept && (op == OP_MTLO)) begin
            lo <= a;
        end else if (state == ST_MUL) begin
            lo <= alu_r;
            hi <= alu_r2;
        end else if (state == ST_FIX) begin
            if (sgn.dz) begin
                lo <= '1;
                hi <= op_a;
            end else begin
                lo <= q_fix;
                hi <= r_fix;
            end
        end
    end

    // MF* read port: only meaningful while IDLE, zero otherwise.
    always_comb begin
        result       = '0;
        result_valid = 1'b0;
        if ((state == ST_IDLE) && op_valid) begin
            if (op == OP_MFHI) begin
                result       = hi;
                result_valid = 1'b1;
            end else if (op == OP_MFLO) begin
                result       = lo;
                result_valid = 1'b1;
            end
        end
    end

    // ALU ownership: only the MUL cycle takes the ALU from the execute stage.
    always_comb begin
        alu_ctrl = ex_ctrl;
        alu_a    = ex_a;
        alu_b    = ex_b;
        if (state == ST_MUL) begin
            alu_ctrl = MUL_CTRL;
            alu_a    = op_a;
            alu_b    = op_b;
        end
    end

    assign busy        = (state != ST_IDLE);
    assign stall       = (state == ST_MUL) ||
                         ((state != ST_IDLE) && op_valid && (op != OP_NOP));
    assign div_by_zero = (state == ST_FIX) && sgn.dz;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: directed scenarios plus randomized ops checked
// against an arithmetic HI/LO model and a behavioural ALU.
module tb_hilo_ctrl;
    import mmips_hilo_pkg::*;

    localparam logic [5:0] ADD = 6'h20;

    logic        clk = 1'b0;
    logic        rst_n, op_valid;
    logic [2:0]  op;
    logic [31:0] a, b, ex_a, ex_b, alu_a, alu_b, alu_r, alu_r2, result;
    logic [5:0]  ex_ctrl, alu_ctrl;
    logic        result_valid, busy, stall, div_by_zero;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] mhi = '0, mlo = '0;

    hilo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_r(alu_r), .alu_r2(alu_r2), .result(result),
        .result_valid(result_valid), .busy(busy), .stall(stall),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU.
    logic [63:0] prod;
    always_comb begin
        prod   = 64'(alu_a) * 64'(alu_b);
        alu_r  = alu_a ^ alu_b;
        alu_r2 = '0;
        if (alu_ctrl == 6'h13) begin
            alu_r  = prod[31:0];
            alu_r2 = prod[63:32];
        end else if (alu_ctrl == ADD) begin
            alu_r = alu_a + alu_b;
        end
    end

    // Reference HI/LO update from the architectural rules.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, q, r;
        case (o)
            OP_MULTU: begin p = 64'(x) * 64'(y); mhi = p[63:32]; mlo = p[31:0]; end
            OP_DIVU: begin
                if (y == 0) begin mlo = 32'hFFFF_FFFF; mhi = x; end
                else begin mlo = x / y; mhi = x % y; end
            end
            OP_DIV: begin
                if (y == 0) begin mlo = 32'hFFFF_FFFF; mhi = x; end
                else begin
                    sx = longint'($signed(x)); sy = longint'($signed(y));
                    q = sx / sy; r = sx % sy;
                    mlo = q[31:0]; mhi = r[31:0];
                end
            end
            OP_MTHI: mhi = x;
            OP_MTLO: mlo = x;
            default: ;
        endcase
    endtask

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
        if (o == OP_MULTU) return 1;
        if (o == OP_DIVU || o == OP_DIV) return (y == 0) ? 1 : 33;
        return 0;
    endfunction

    task automatic cyc;
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op_valid = 1'b1; op = o; a = x; b = y;
        cyc;
        op_valid = 1'b0; op = OP_NOP;
    endtask

    // Counts busy cycles, bounded so a stuck FSM cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        #1;
        while (busy && n < 100) begin
            n++;
            cyc; #1;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l,
                             output logic vh, output logic vl);
        op_valid = 1'b1; op = OP_MFHI;
        #1 h = result; vh = result_valid;
        op = OP_MFLO;
        #1 l = result; vl = result_valid;
        op_valid = 1'b0; op = OP_NOP;
        cyc;
    endtask

    task automatic test_reset;
        logic [31:0] h, l; logic vh, vl;
        rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP; a = '0; b = '0;
        ex_ctrl = ADD; ex_a = 32'h1111_2222; ex_b = 32'h0000_0003;
        cyc; cyc; #1;
        vectors++;
        if ({busy, stall, div_by_zero, result_valid} !== 4'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs busy/stall/dz/rv=%b%b%b%b result=%h required 0000/0",
                     busy, stall, div_by_zero, result_valid, result);
        end
        vectors++;
        if (alu_ctrl !== ex_ctrl || alu_a !== ex_a || alu_b !== ex_b) begin
            miscompares++;
            $display("FAIL reset_alu_mux ctrl=%h a=%h b=%h required %h %h %h",
                     alu_ctrl, alu_a, alu_b, ex_ctrl, ex_a, ex_b);
        end
        rst_n = 1'b1; cyc;
        issue(OP_MTHI, 32'hDEAD_BEEF, 0);
        issue(OP_DIVU, 1000, 7);
        repeat (5) cyc;
        rst_n = 1'b0; cyc; cyc; #1;
        vectors++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_div busy=%b stall=%b required 0 0", busy, stall);
        end
        rst_n = 1'b1; cyc;
        mhi = '0; mlo = '0;
        read_hilo(h, l, vh, vl);
        vectors++;
        if (h !== 32'h0 || l !== 32'h0 || !vh || !vl) begin
            miscompares++;
            $display("FAIL reset_hilo hi=%h lo=%h valid=%b%b required 0 0 11", h, l, vh, vl);
        end
    endtask

    task automatic test_multu;
        logic [31:0] h, l; logic vh, vl; int n;
        ex_ctrl = ADD; ex_a = $urandom; ex_b = $urandom;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        #1;
        vectors++;
        if (alu_ctrl !== 6'h13 || stall !== 1'b1 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd2) begin
            miscompares++;
            $display("FAIL multu_mul_cycle ctrl=%h stall=%b a=%h b=%h required 13 1 ffffffff 2",
                     alu_ctrl, stall, alu_a, alu_b);
        end
        cyc; #1;
        vectors++;
        if (busy !== 1'b0 || alu_ctrl !== ex_ctrl || alu_a !== ex_a || alu_b !== ex_b) begin
            miscompares++;
            $display("FAIL multu_passthru busy=%b ctrl=%h a=%h required 0 %h %h",
                     busy, alu_ctrl, alu_a, ex_ctrl, ex_a);
        end
        wait_idle(n);
        model(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (h !== 32'h1 || l !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL multu_hilo hi=%h lo=%h required 00000001 fffffffe", h, l);
        end
    endtask

    task automatic test_divu;
        logic [31:0] h, l; logic vh, vl; int n;
        issue(OP_DIVU, 100, 13);
        wait_idle(n);
        vectors++;
        if (n != 33) begin
            miscompares++;
            $display("FAIL divu_busy_cycles got %0d required 33", n);
        end
        model(OP_DIVU, 100, 13);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (l !== 32'd7 || h !== 32'd9) begin
            miscompares++;
            $display("FAIL divu_hilo hi=%h lo=%h required 9 7", h, l);
        end
    endtask

    task automatic test_div;
        logic [31:0] h, l; logic vh, vl; int n;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        model(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div_neg7_by_2 hi=%h lo=%h required ffffffff fffffffd", h, l);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (l !== 32'h8000_0000 || h !== 32'h0) begin
            miscompares++;
            $display("FAIL div_overflow hi=%h lo=%h required 0 80000000", h, l);
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] h, l; logic vh, vl;
        issue(OP_DIVU, 32'h1234, 32'd0);
        #1;
        vectors++;
        if (div_by_zero !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL dz_pulse dz=%b busy=%b required 1 1", div_by_zero, busy);
        end
        cyc; #1;
        vectors++;
        if (div_by_zero !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dz_end dz=%b busy=%b required 0 0", div_by_zero, busy);
        end
        model(OP_DIVU, 32'h1234, 32'd0);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (l !== 32'hFFFF_FFFF || h !== 32'h1234) begin
            miscompares++;
            $display("FAIL dz_hilo hi=%h lo=%h required 1234 ffffffff", h, l);
        end
    endtask

    task automatic test_mf_during_div;
        logic [31:0] x, y;
        int n;
        x = $urandom; y = $urandom_range(1, 5000);
        op_valid = 1'b1; op = OP_DIVU; a = x; b = y;
        cyc;
        op = OP_MFLO; a = $urandom; b = $urandom;
        model(OP_DIVU, x, y);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            ex_ctrl = ADD; ex_a = $urandom; ex_b = $urandom;
            #1;
            if (busy) begin
                n++;
                vectors++;
                if (stall !== 1'b1 || result_valid !== 1'b0 || alu_r !== ex_a + ex_b) begin
                    miscompares++;
                    $display("FAIL mf_wait cyc%0d stall=%b rv=%b alu_r=%h required 1 0 %h",
                             k, stall, result_valid, alu_r, ex_a + ex_b);
                end
                cyc;
            end else begin
                vectors++;
                if (stall !== 1'b0 || result_valid !== 1'b1 || result !== mlo ||
                    alu_r !== ex_a + ex_b) begin
                    miscompares++;
                    $display("FAIL mf_return stall=%b rv=%b result=%h alu_r=%h required 0 1 %h %h",
                             stall, result_valid, result, alu_r, mlo, ex_a + ex_b);
                end
                break;
            end
        end
        vectors++;
        if (n != 33) begin
            miscompares++;
            $display("FAIL mf_stall_cycles got %0d required 33", n);
        end
        op_valid = 1'b0; op = OP_NOP;
        cyc;
    endtask

    task automatic test_back_to_back_mt;
        logic [31:0] x, y, h, l; logic vh, vl;
        x = $urandom; y = $urandom;
        issue(OP_MTHI, x, 0);
        issue(OP_MTLO, y, 0);
        model(OP_MTHI, x, 0);
        model(OP_MTLO, y, 0);
        read_hilo(h, l, vh, vl);
        vectors++;
        if (h !== mhi || l !== mlo || !vh || !vl) begin
            miscompares++;
            $display("FAIL mt_b2b hi=%h lo=%h valid=%b%b required %h %h 11", h, l, vh, vl, mhi, mlo);
        end
    endtask

    task automatic test_random;
        logic [2:0]  o;
        logic [31:0] x, y, h, l;
        logic        vh, vl;
        int          n, sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: o = OP_MULTU; 1: o = OP_DIVU; 2: o = OP_DIV;
                3: o = OP_MTHI;  default: o = OP_MTLO;
            endcase
            x = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = $urandom_range(1, 64);
                2: y = -32'($urandom_range(1, 64));
                default: y = $urandom;
            endcase
            ex_ctrl = ADD; ex_a = $urandom; ex_b = $urandom;
            issue(o, x, y);
            wait_idle(n);
            vectors++;
            if (n != exp_lat(o, y)) begin
                miscompares++;
                $display("FAIL rnd%0d_latency op=%0d b=%h got %0d required %0d",
                         i, o, y, n, exp_lat(o, y));
            end
            model(o, x, y);
            read_hilo(h, l, vh, vl);
            vectors++;
            if (h !== mhi || l !== mlo || !vh || !vl) begin
                miscompares++;
                $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h hi=%h lo=%h required %h %h",
                         i, o, x, y, h, l, mhi, mlo);
            end
        end
    endtask

    initial begin
        test_reset;
        test_multu;
        test_divu;
        test_div;
        test_div_zero;
        test_mf_during_div;
        test_back_to_back_mt;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
